cam_match_core: RTL
===================

# cam_match_core

Content-addressable match engine of the CAM kernel datapath. Sits between the kernel's input AXI4-Stream handshake and the output write FIFO. Decodes one command word per valid input cycle (write, search, clear) against a CAM_SIZE-entry key table and emits one result word per SEARCH. Fixed 3-cycle latency, no backpressure input; the parent throttles s_tvalid through the FIFO prog_full threshold.

## Interface
Parameters:
- C_DATA_WIDTH, 64: command/result word width; must be ≥ KEY_WIDTH + IDX_W + 2.
- CAM_SIZE, 64: number of table entries, 2..1024.
- KEY_WIDTH, 32: key width.
- IDX_W (localparam): $clog2(CAM_SIZE), minimum 1.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_tvalid  in  1  command valid; the parent gates it with its accept handshake.
- s_tdata  in  C_DATA_WIDTH  command word.
- m_tvalid  out  1  result valid, one-cycle pulse per SEARCH.
- m_tdata  out  C_DATA_WIDTH  result word.

## Operation
- Command fields:
  - opcode = s_tdata[C_DATA_WIDTH-1 -: 2]
  - key = s_tdata[KEY_WIDTH-1:0]
  - index = s_tdata[KEY_WIDTH +: IDX_W]
  - remaining bits ignored.
- Opcodes:
  - 00 NOP: no effect, no output.
  - 01 WRITE: entry[index] ← {valid=1, key}. No output. If index ≥ CAM_SIZE, the command is dropped silently.
  - 10 SEARCH: compares key against all valid entries and produces one result.
  - 11 CLEAR: all valid bits ← 0. No output.
- Table state (key registers plus valid bits) updates at the same edge that samples the WRITE or CLEAR.
- Strict command ordering: a SEARCH observes every earlier WRITE/CLEAR, including one sampled the immediately preceding cycle. There is no hazard window.
- Result word (all unnamed bits 0):
  - [C_DATA_WIDTH-1] hit.
  - [IDX_W-1:0] lowest matching index; 0 on miss.
  - [IDX_W +: KEY_WIDTH] searched key, echoed.
- Duplicate keys in the table are legal; the lowest index wins.
- Pipeline stages:
  - S0: capture opcode/key and apply table writes.
  - S1: register the CAM_SIZE-bit match vector (key equality AND valid).
  - S2: priority-encode and register m_tdata/m_tvalid.
- Each stage carries its own valid bit. Only SEARCH sets the valid bit through the pipeline.

## Timing
- Reset (areset=1 at an edge):
  - all valid bits, stage valids and m_tvalid ← 0; m_tdata ← 0.
  - key registers need not be reset.
- Reset mid-operation: in-flight SEARCHes are discarded, no result is produced, and the table is empty afterwards.
- Latency: SEARCH with s_tvalid=1 in cycle k → m_tvalid=1 with result in cycle k+3.
- Throughput: one command per cycle sustained; back-to-back SEARCHes produce back-to-back results.
- m_tvalid is never asserted without a corresponding SEARCH.
- At most one output per input command. This keeps the parent's FIFO headroom of 5 ≥ 3 in-flight words valid.
- WRITE in cycle k, SEARCH of the same key in cycle k+1 → hit, reported in cycle k+4.
- CLEAR in cycle k, SEARCH in k+1 → miss. A SEARCH in cycle k−1 still sees the pre-clear table.
- WRITE overwriting an existing entry replaces the old key from the next cycle onward.
- areset has priority over s_tvalid in the same cycle; the command is dropped.

## Configuration
- CAM_MULTI_HIT_EN defined:
  - m_tdata[C_DATA_WIDTH-2] = multi-hit flag, 1 when two or more valid entries match.
  - Requires C_DATA_WIDTH ≥ KEY_WIDTH + IDX_W + 3; otherwise elaboration fails via an assertion.
- Undefined:
  - the bit is constant 0.
  - no population/second-match logic is built.
  - latency is unchanged either way.

## Test plan
- Reset, then SEARCH key 0x0000_0000 → cycle +3 result hit=0, index=0, key echo 0. m_tvalid is 0 throughout reset and for the 2 cycles before the result.
- WRITE idx 5 key 0xDEAD_BEEF, next cycle SEARCH 0xDEAD_BEEF → hit=1, index=5, exactly 3 cycles after the SEARCH.
- WRITE idx 3 and idx 9 both with key 0x1234, then SEARCH 0x1234 → index=3.
  - With CAM_MULTI_HIT_EN: multi-hit bit = 1.
  - Without it: multi-hit bit = 0.
- Fill all 64 entries with keys i+100, then stream 64 back-to-back SEARCHes → 64 consecutive m_tvalid cycles, each index = key−100.
- CLEAR immediately followed by SEARCH of a stored key → miss. A SEARCH issued one cycle before the CLEAR → hit.
- Issue 3 SEARCHes, assert areset for 1 cycle while they are in flight → no m_tvalid. A subsequent SEARCH of a previously written key → miss.

Source files
------------

// File: rtl/cam_match_core.sv
`default_nettype none
// ============================================================================
// Module      : cam_match_core
// Description : Three-stage CAM match engine. It decodes WRITE, SEARCH and
//               CLEAR commands against a CAM_SIZE-entry key table and returns
//               one result word per SEARCH. Optional feature macro:
//               CAM_MULTI_HIT_EN adds a multi-hit flag to each result.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_match_core #(
    parameter int C_DATA_WIDTH = 64,
    parameter int CAM_SIZE     = 64,
    parameter int KEY_WIDTH    = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_tdata,
    output logic                    m_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_tdata
);

    localparam int IDX_W = (CAM_SIZE > 1) ? $clog2(CAM_SIZE) : 1;

    localparam logic [1:0] c_OP_WRITE  = 2'b01;
    localparam logic [1:0] c_OP_SEARCH = 2'b10;
    localparam logic [1:0] c_OP_CLEAR  = 2'b11;

    localparam int c_HIT_BIT   = C_DATA_WIDTH - 1;
    localparam int c_MULTI_BIT = C_DATA_WIDTH - 2;

    generate
        if (C_DATA_WIDTH < KEY_WIDTH + IDX_W + 2) begin : g_bad_data_width
            $error("cam_match_core: C_DATA_WIDTH too narrow for key, index and flags");
        end
        if ((CAM_SIZE < 2) || (CAM_SIZE > 1024)) begin : g_bad_cam_size
            $error("cam_match_core: CAM_SIZE must be in 2..1024");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [1:0]           w_op;
    logic [KEY_WIDTH-1:0] w_key;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_idx_ok;
    logic                 w_wr_en;
    logic                 w_clr_en;
    logic                 w_srch_en;
    logic                 w_unused_bits;

    assign w_op          = s_tdata[C_DATA_WIDTH-1 -: 2];
    assign w_key         = s_tdata[KEY_WIDTH-1:0];
    assign w_idx         = s_tdata[KEY_WIDTH +: IDX_W];
    assign w_unused_bits = ^s_tdata;

    generate
        if ((1 << IDX_W) == CAM_SIZE) begin : g_idx_dense
            assign w_idx_ok = 1'b1;
        end else begin : g_idx_sparse
            assign w_idx_ok = ({1'b0, w_idx} < (IDX_W + 1)'(CAM_SIZE));
        end
    endgenerate

    // A command sampled together with reset is dropped entirely.
    assign w_wr_en   = s_tvalid && !areset && (w_op == c_OP_WRITE) && w_idx_ok;
    assign w_clr_en  = s_tvalid && !areset && (w_op == c_OP_CLEAR);
    assign w_srch_en = s_tvalid && !areset && (w_op == c_OP_SEARCH);

    // ------------------------------------------------------------------
    // Key table: keys are data only, the valid bits carry the state
    // ------------------------------------------------------------------
    logic [KEY_WIDTH-1:0] r_key [CAM_SIZE];
    logic [CAM_SIZE-1:0]  r_valid;

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_key[w_idx] <= w_key;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_valid <= '0;
        end else if (w_clr_en) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // S0: capture search key
    // ------------------------------------------------------------------
    logic                 r_s0_valid;
    logic [KEY_WIDTH-1:0] r_s0_key;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s0_valid <= 1'b0;
        end else begin
            r_s0_valid <= w_srch_en;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_srch_en) begin
            r_s0_key <= w_key;
        end
    end

    // ------------------------------------------------------------------
    // S1: match vector against the table as left by all earlier commands
    // ------------------------------------------------------------------
    logic [CAM_SIZE-1:0]  w_match;
    logic                 r_s1_valid;
    logic [CAM_SIZE-1:0]  r_s1_match;
    logic [KEY_WIDTH-1:0] r_s1_key;

    generate
        for (genvar g = 0; g < CAM_SIZE; g++) begin : g_match
            assign w_match[g] = r_valid[g] && (r_key[g] == r_s0_key);
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s0_valid;
        end
    end

    always_ff @(posedge aclk) begin
        if (r_s0_valid) begin
            r_s1_match <= w_match;
            r_s1_key   <= r_s0_key;
        end
    end

    // ------------------------------------------------------------------
    // S2: lowest-index priority encode and result assembly
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]        w_pe_idx;
    logic                    w_hit;
    logic                    w_multi;
    logic [C_DATA_WIDTH-1:0] w_result;

    always_comb begin
        w_pe_idx = '0;
        for (int i = CAM_SIZE - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_pe_idx = IDX_W'(i);
            end
        end
    end

    assign w_hit = |r_s1_match;

`ifdef CAM_MULTI_HIT_EN
    generate
        if (C_DATA_WIDTH < KEY_WIDTH + IDX_W + 3) begin : g_bad_multi_width
            $error("cam_match_core: C_DATA_WIDTH too narrow for the multi-hit flag");
        end
    endgenerate

    // Clearing the lowest set bit leaves something only if two or more matched.
    localparam logic [CAM_SIZE-1:0] c_ONE = {{(CAM_SIZE-1){1'b0}}, 1'b1};
    assign w_multi = |(r_s1_match & (r_s1_match - c_ONE));
`else
    assign w_multi = 1'b0;
`endif

    always_comb begin
        w_result                     = '0;
        w_result[c_HIT_BIT]          = w_hit;
        w_result[c_MULTI_BIT]        = w_multi;
        w_result[IDX_W-1:0]          = w_pe_idx;
        w_result[IDX_W +: KEY_WIDTH] = r_s1_key;
    end

    logic                    r_m_tvalid;
    logic [C_DATA_WIDTH-1:0] r_m_tdata;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else begin
            r_m_tvalid <= r_s1_valid;
            if (r_s1_valid) begin
                r_m_tdata <= w_result;
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;

endmodule
`default_nettype wire
